// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags.
// Commits from the reorder buffer write values and retire pending renames.
// Renames from the decoder mark registers busy with a producer tag.
// Source queries return either the committed value or the producer tag.
// A commit in the same cycle as a query is forwarded through a bypass.
module reg_rename_file #(
  parameter int REG_COUNT = 32,
  parameter int REG_IDX_W = 5,
  parameter int ROB_TAG_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_rdy,
  input  logic                 in_flush_enable,
  input  logic                 in_rob_commit_enable,
  input  logic [REG_IDX_W-1:0] in_rob_commit_rd,
  input  logic [DATA_W-1:0]    in_rob_commit_value,
  input  logic [ROB_TAG_W-1:0] in_rob_commit_reorder,
  input  logic                 in_decoder_rename_enable,
  input  logic [REG_IDX_W-1:0] in_decoder_rename_rd,
  input  logic [ROB_TAG_W-1:0] in_decoder_rename_reorder,
  input  logic [REG_IDX_W-1:0] in_decoder_rs,
  input  logic [REG_IDX_W-1:0] in_decoder_rt,
  output logic                 out_decoder_rs_busy,
  output logic [DATA_W-1:0]    out_decoder_rs_value,
  output logic [ROB_TAG_W-1:0] out_decoder_rs_reorder,
  output logic                 out_decoder_rt_busy,
  output logic [DATA_W-1:0]    out_decoder_rt_value,
  output logic [ROB_TAG_W-1:0] out_decoder_rt_reorder,
  output logic [31:0]          out_commit_count
);

  // Architectural state: committed value, pending flag and producer tag.
  logic [DATA_W-1:0]    value_q [REG_COUNT];
  logic [DATA_W-1:0]    value_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic [ROB_TAG_W-1:0] tag_q   [REG_COUNT];
  logic [ROB_TAG_W-1:0] tag_d   [REG_COUNT];
  logic [31:0]          count_q;
  logic [31:0]          count_d;

  // Register 0 is hardwired, so commits and renames aimed at it do nothing.
  logic commit_live;
  logic rename_live;

  assign commit_live = in_rob_commit_enable && (in_rob_commit_rd != '0);
  // A flush discards any rename issued in the same cycle.
  assign rename_live = in_decoder_rename_enable && !in_flush_enable &&
                       (in_decoder_rename_rd != '0);

  // Every real commit is counted, including those that coincide with a flush.
  assign count_d = count_q + (commit_live ? 32'd1 : 32'd0);

  // Per-register next-state logic.
  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign value_d[gi] = '0;
      assign busy_d[gi]  = 1'b0;
      assign tag_d[gi]   = '0;
    end else begin : g_live
      logic                 commit_hit;
      logic                 rename_hit;
      logic                 tag_match;
      logic                 busy_nx;
      logic [DATA_W-1:0]    value_nx;
      logic [ROB_TAG_W-1:0] tag_nx;

      assign commit_hit = commit_live && (in_rob_commit_rd == REG_IDX_W'(gi));
      assign rename_hit = rename_live && (in_decoder_rename_rd == REG_IDX_W'(gi));
      assign tag_match  = (tag_q[gi] == in_rob_commit_reorder);

      // Priority for the pending flag: flush, then rename, then a matching
      // commit. A commit with a stale tag (ROB wrapped) must not clear it.
      always_comb begin
        value_nx = value_q[gi];
        busy_nx  = busy_q[gi];
        tag_nx   = tag_q[gi];
        if (commit_hit) begin
          value_nx = in_rob_commit_value;
        end
        if (in_flush_enable) begin
          busy_nx = 1'b0;
        end else if (rename_hit) begin
          busy_nx = 1'b1;
          tag_nx  = in_decoder_rename_reorder;
        end else if (commit_hit && tag_match) begin
          busy_nx = 1'b0;
        end
      end

      assign value_d[gi] = value_nx;
      assign busy_d[gi]  = busy_nx;
      assign tag_d[gi]   = tag_nx;
    end
  end

  // State register: asynchronous clear, updates only when globally ready.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else if (in_rdy) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Two identical query ports: index 0 serves rs, index 1 serves rt.
  for (genvar gi = 0; gi < 2; gi++) begin : g_query
    logic [REG_IDX_W-1:0] src;
    logic                 bypass;
    logic                 busy_o;
    logic [DATA_W-1:0]    value_o;
    logic [ROB_TAG_W-1:0] reorder_o;

    assign src = (gi == 0) ? in_decoder_rs : in_decoder_rt;

    // Forward a same-cycle commit only when it retires the pending producer.
    assign bypass = in_rob_commit_enable && (in_rob_commit_rd == src) &&
                    busy_q[src] && (tag_q[src] == in_rob_commit_reorder);

    // Query reflects pre-rename state; register 0 always reads as zero.
    always_comb begin
      busy_o    = 1'b0;
      value_o   = '0;
      reorder_o = '0;
      if (src != '0) begin
        reorder_o = tag_q[src];
        if (bypass) begin
          busy_o  = 1'b0;
          value_o = in_rob_commit_value;
        end else begin
          busy_o  = busy_q[src];
          value_o = value_q[src];
        end
      end
    end
  end

  assign out_decoder_rs_busy    = g_query[0].busy_o;
  assign out_decoder_rs_value   = g_query[0].value_o;
  assign out_decoder_rs_reorder = g_query[0].reorder_o;
  assign out_decoder_rt_busy    = g_query[1].busy_o;
  assign out_decoder_rt_value   = g_query[1].value_o;
  assign out_decoder_rt_reorder = g_query[1].reorder_o;
  assign out_commit_count       = count_q;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file. Stimulus pushes the hand-computed
// expected query response into a queue and raises a sample strobe; a
// separate monitor pops and compares on the falling edge.
module tb_reg_rename_file;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        flush;
  logic        c_en;
  logic [4:0]  c_rd;
  logic [31:0] c_val;
  logic [3:0]  c_reo;
  logic        r_en;
  logic [4:0]  r_rd;
  logic [3:0]  r_reo;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_busy;
  logic [31:0] rs_value;
  logic [3:0]  rs_reo;
  logic        rt_busy;
  logic [31:0] rt_value;
  logic [3:0]  rt_reo;
  logic [31:0] count;

  reg_rename_file dut (
    .in_clk                    (clk),
    .in_rst_n                  (rst_n),
    .in_rdy                    (rdy),
    .in_flush_enable           (flush),
    .in_rob_commit_enable      (c_en),
    .in_rob_commit_rd          (c_rd),
    .in_rob_commit_value       (c_val),
    .in_rob_commit_reorder     (c_reo),
    .in_decoder_rename_enable  (r_en),
    .in_decoder_rename_rd      (r_rd),
    .in_decoder_rename_reorder (r_reo),
    .in_decoder_rs             (rs),
    .in_decoder_rt             (rt),
    .out_decoder_rs_busy       (rs_busy),
    .out_decoder_rs_value      (rs_value),
    .out_decoder_rs_reorder    (rs_reo),
    .out_decoder_rt_busy       (rt_busy),
    .out_decoder_rt_value      (rt_value),
    .out_decoder_rt_reorder    (rt_reo),
    .out_commit_count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rs_b;
    logic [31:0] rs_v;
    logic [3:0]  rs_t;
    bit          rs_tchk;
    bit          use_rt;
    logic        rt_b;
    logic [31:0] rt_v;
    logic [3:0]  rt_t;
    bit          rt_tchk;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  bit   chk;
  int   checks;
  int   failures;

  function automatic exp_t mk(string n, logic rb, logic [31:0] rv, logic [3:0] rtg,
                              bit rtc, logic [31:0] cnt);
    exp_t e;
    e.name = n; e.rs_b = rb; e.rs_v = rv; e.rs_t = rtg; e.rs_tchk = rtc;
    e.use_rt = 1'b0; e.rt_b = 1'b0; e.rt_v = '0; e.rt_t = '0; e.rt_tchk = 1'b0;
    e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t with_rt(exp_t ein, logic b, logic [31:0] v, logic [3:0] t, bit tc);
    exp_t e;
    e = ein;
    e.use_rt = 1'b1; e.rt_b = b; e.rt_v = v; e.rt_t = t; e.rt_tchk = tc;
    return e;
  endfunction

  task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=0x%08h required=0x%08h", n, f, act, req);
    end
  endtask

  // Monitor: pops one expectation per strobed cycle and compares.
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=empty required=entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.name, "rs_busy", 32'(rs_busy), 32'(e.rs_b));
        if (!e.rs_b) cmp(e.name, "rs_value", rs_value, e.rs_v);
        if (e.rs_b || e.rs_tchk) cmp(e.name, "rs_reorder", 32'(rs_reo), 32'(e.rs_t));
        if (e.use_rt) begin
          cmp(e.name, "rt_busy", 32'(rt_busy), 32'(e.rt_b));
          if (!e.rt_b) cmp(e.name, "rt_value", rt_value, e.rt_v);
          if (e.rt_b || e.rt_tchk) cmp(e.name, "rt_reorder", 32'(rt_reo), 32'(e.rt_t));
        end
        cmp(e.name, "count", count, e.cnt);
        $display("txn %-12s rs=%0d busy=%0b val=0x%08h reo=%0d rt=%0d busy=%0b count=%0d",
                 e.name, rs, rs_busy, rs_value, rs_reo, rt, rt_busy, count);
      end
    end
  end

  task automatic idle();
    rdy = 1'b1; flush = 1'b0;
    c_en = 1'b0; c_rd = '0; c_val = '0; c_reo = '0;
    r_en = 1'b0; r_rd = '0; r_reo = '0;
    rs = '0; rt = '0;
  endtask

  task automatic commit(logic [4:0] rd, logic [3:0] reo, logic [31:0] v);
    c_en = 1'b1; c_rd = rd; c_reo = reo; c_val = v;
  endtask

  task automatic rename(logic [4:0] rd, logic [3:0] reo);
    r_en = 1'b1; r_rd = rd; r_reo = reo;
  endtask

  // Inputs are already applied; optionally queue an expectation, then
  // advance to just after the next rising edge and return to idle inputs.
  task automatic step(bit do_chk, exp_t e);
    if (do_chk) exp_q.push_back(e);
    chk = do_chk;
    @(posedge clk);
    #1;
    chk = 1'b0;
    idle();
  endtask

  exp_t none;

  initial begin
    checks = 0; failures = 0; chk = 1'b0;
    none = mk("none", 1'b0, '0, '0, 1'b0, '0);
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values and asynchronous reset mid-operation.
    rs = 5'd3;
    step(1'b1, mk("reset_state", 1'b0, 32'd0, 4'd0, 1'b1, 32'd0));
    rename(5'd3, 4'd5);
    step(1'b0, none);
    rs = 5'd3;
    step(1'b1, mk("x3_busy", 1'b1, 32'd0, 4'd5, 1'b1, 32'd0));
    rst_n = 1'b0; rs = 5'd3;
    step(1'b1, mk("async_reset", 1'b0, 32'd0, 4'd0, 1'b1, 32'd0));
    rst_n = 1'b1;

    // Rename, same-cycle bypass, then the registered value.
    rename(5'd5, 4'd2);
    step(1'b0, none);
    rs = 5'd5;
    step(1'b1, mk("x5_renamed", 1'b1, 32'd0, 4'd2, 1'b1, 32'd0));
    commit(5'd5, 4'd2, 32'h1234); rs = 5'd5; rt = 5'd5;
    step(1'b1, with_rt(mk("x5_bypass", 1'b0, 32'h1234, 4'd0, 1'b0, 32'd0),
                       1'b0, 32'h1234, 4'd0, 1'b0));
    rs = 5'd5;
    step(1'b1, mk("x5_commit", 1'b0, 32'h1234, 4'd0, 1'b0, 32'd1));

    // Stale-tag commit keeps the newer rename pending.
    rename(5'd7, 4'd1);
    step(1'b0, none);
    rename(5'd7, 4'd4);
    step(1'b0, none);
    commit(5'd7, 4'd1, 32'd9); rs = 5'd7;
    step(1'b1, mk("x7_stale_cm", 1'b1, 32'd0, 4'd4, 1'b1, 32'd1));
    rs = 5'd7;
    step(1'b1, mk("x7_after", 1'b1, 32'd0, 4'd4, 1'b1, 32'd2));

    // Same-cycle commit and rename of x8: rename wins busy/tag.
    rename(5'd8, 4'd3);
    step(1'b0, none);
    commit(5'd8, 4'd3, 32'hAB); rename(5'd8, 4'd6); rs = 5'd8;
    step(1'b1, mk("x8_cm_rn", 1'b0, 32'hAB, 4'd0, 1'b0, 32'd2));
    rs = 5'd8;
    step(1'b1, mk("x8_after", 1'b1, 32'd0, 4'd6, 1'b1, 32'd3));
    // Value written by that commit shows once the tag-6 producer commits.
    commit(5'd8, 4'd6, 32'hCD); rs = 5'd8;
    step(1'b1, mk("x8_bypass2", 1'b0, 32'hCD, 4'd0, 1'b0, 32'd3));
    rs = 5'd8;
    step(1'b1, mk("x8_value", 1'b0, 32'hCD, 4'd6, 1'b1, 32'd4));

    // Flush clears all pending renames and drops the same-cycle rename.
    rename(5'd1, 4'd1);
    step(1'b0, none);
    rename(5'd2, 4'd2);
    step(1'b0, none);
    rename(5'd3, 4'd3);
    step(1'b0, none);
    rs = 5'd1; rt = 5'd2;
    step(1'b1, with_rt(mk("pre_flush12", 1'b1, 32'd0, 4'd1, 1'b1, 32'd4),
                       1'b1, 32'd0, 4'd2, 1'b1));
    flush = 1'b1; rename(5'd4, 4'd7); rs = 5'd3; rt = 5'd4;
    step(1'b1, with_rt(mk("flush_cycle", 1'b1, 32'd0, 4'd3, 1'b1, 32'd4),
                       1'b0, 32'd0, 4'd0, 1'b1));
    rs = 5'd1; rt = 5'd2;
    step(1'b1, with_rt(mk("post_flush12", 1'b0, 32'd0, 4'd0, 1'b0, 32'd4),
                       1'b0, 32'd0, 4'd0, 1'b0));
    rs = 5'd3; rt = 5'd4;
    step(1'b1, with_rt(mk("post_flush34", 1'b0, 32'd0, 4'd0, 1'b0, 32'd4),
                       1'b0, 32'd0, 4'd0, 1'b1));
    rs = 5'd7; rt = 5'd8;
    step(1'b1, with_rt(mk("post_flush78", 1'b0, 32'd9, 4'd0, 1'b0, 32'd4),
                       1'b0, 32'hCD, 4'd0, 1'b0));

    // Register 0 ignores commits and renames.
    commit(5'd0, 4'd0, 32'hFFFF); rename(5'd0, 4'd5); rs = 5'd0; rt = 5'd0;
    step(1'b1, with_rt(mk("x0_cycle", 1'b0, 32'd0, 4'd0, 1'b1, 32'd4),
                       1'b0, 32'd0, 4'd0, 1'b1));
    rs = 5'd0;
    step(1'b1, mk("x0_after", 1'b0, 32'd0, 4'd0, 1'b1, 32'd4));

    // Global ready low: commit and rename to x9 have no effect.
    rdy = 1'b0; commit(5'd9, 4'd0, 32'h55); rename(5'd10, 4'd2); rs = 5'd9;
    step(1'b0, none);
    rs = 5'd9; rt = 5'd10;
    step(1'b1, with_rt(mk("rdy_low_x9", 1'b0, 32'd0, 4'd0, 1'b1, 32'd4),
                       1'b0, 32'd0, 4'd0, 1'b1));

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
